// File: rtl/ble_deframer.sv
// BLE link-layer deframer: hunts for the access address, de-whitens the
// PDU, streams header/payload bytes over a valid/ready port and checks
// the trailing CRC-24.
module ble_deframer #(
  parameter logic [31:0] AA       = 32'h8E89BED6,
  parameter int          MAX_ERR  = 1,
  parameter int          MAX_LEN  = 37,
  parameter logic [23:0] CRC_INIT = 24'h555555
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] ch_idx,
  input  logic       rx_bit,
  input  logic       rx_bit_valid,
  output logic [7:0] m_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       m_last,
  output logic       pkt_start,
  output logic       pkt_done,
  output logic       crc_ok,
  output logic       len_err,
  output logic       overflow,
  output logic       busy
);

  typedef enum logic [1:0] {S_HUNT, S_HEADER, S_PAYLOAD, S_CRC} state_t;

  state_t      r_state, w_state_nxt;
  // Only the upper 31 bits of the hunt window are kept: the oldest bit
  // falls out on the same shift that brings the newest bit in.
  logic [30:0] r_sr;
  logic [6:0]  r_w;
  logic [23:0] r_c;
  logic [4:0]  r_bitcnt;
  logic [7:0]  r_bytecnt;
  logic [7:0]  r_len;
  logic [6:0]  r_sh;
  logic [7:0]  r_mdata;
  logic        r_mvalid, r_mlast, r_pkt_start, r_pkt_done;
  logic        r_crc_ok, r_len_err, r_ovf;

  logic [31:0] w_sr_next, w_diff;
  logic [5:0]  w_errs;
  logic        w_match;
  logic        w_bit_step, w_d, w_fb;
  logic [6:0]  w_w_next;
  logic [23:0] w_c_next;
  logic [7:0]  w_byte;
  logic        w_byte_done, w_buf_free, w_ovf;
  logic        w_is_len, w_len_zero, w_len_bad, w_pay_last, w_last_byte;
  logic        w_crc_end, w_busy;

  assign w_sr_next  = {rx_bit, r_sr};
  assign w_diff     = w_sr_next ^ AA;
  assign w_bit_step = rx_bit_valid && (r_state != S_HUNT);
  assign w_d        = rx_bit ^ r_w[6];
  assign w_w_next   = {r_w[5], r_w[4], r_w[3] ^ r_w[6], r_w[2], r_w[1], r_w[0], r_w[6]};
  assign w_fb       = w_d ^ r_c[23];
  assign w_c_next   = {r_c[22:0], 1'b0} ^ (w_fb ? 24'h00065B : 24'h000000);
  assign w_byte     = {w_d, r_sh};
  assign w_buf_free = !r_mvalid || m_ready;

  // Hamming distance between the hunt window (including this bit) and AA
  always_comb begin
    w_errs = '0;
    for (int i = 0; i < 32; i++) w_errs = w_errs + 6'(w_diff[i]);
  end

  assign w_match = (w_errs <= 6'(MAX_ERR));

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_HUNT;
    else     r_state <= w_state_nxt;
  end

  // Next-state decode; a lost byte or a bad length aborts to HUNT
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_HUNT:    if (rx_bit_valid && w_match) w_state_nxt = S_HEADER;
      S_HEADER:  if (w_byte_done) begin
                   if (w_ovf)                w_state_nxt = S_HUNT;
                   else if (w_is_len) begin
                     if (w_len_bad)          w_state_nxt = S_HUNT;
                     else if (w_len_zero)    w_state_nxt = S_CRC;
                     else                    w_state_nxt = S_PAYLOAD;
                   end
                 end
      S_PAYLOAD: if (w_byte_done) begin
                   if (w_ovf)                w_state_nxt = S_HUNT;
                   else if (w_pay_last)      w_state_nxt = S_CRC;
                 end
      S_CRC:     if (w_crc_end)              w_state_nxt = S_HUNT;
      default:                               w_state_nxt = S_HUNT;
    endcase
  end

  // Per-state output decode: byte boundaries, length checks, busy
  always_comb begin
    w_byte_done = w_bit_step && ((r_state == S_HEADER) || (r_state == S_PAYLOAD))
                  && (r_bitcnt[2:0] == 3'd7);
    w_ovf       = w_byte_done && !w_buf_free;
    w_is_len    = (r_state == S_HEADER) && (r_bytecnt == 8'd1);
    w_len_zero  = (w_byte == 8'd0);
    w_len_bad   = (w_byte > 8'(MAX_LEN));
    // r_bytecnt counts the two header bytes as well, so the last payload
    // byte is number L+1
    w_pay_last  = (r_state == S_PAYLOAD) && ({1'b0, r_bytecnt} == ({1'b0, r_len} + 9'd1));
    w_last_byte = (w_is_len && (w_len_zero || w_len_bad)) || w_pay_last;
    w_crc_end   = w_bit_step && (r_state == S_CRC) && (r_bitcnt == 5'd23);
    w_busy      = (r_state != S_HUNT);
  end

  // Datapath: hunt window, de-whitening, CRC, byte assembly, output buffer
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sr        <= '0;
      r_w         <= '0;
      r_c         <= '0;
      r_bitcnt    <= '0;
      r_bytecnt   <= '0;
      r_len       <= '0;
      r_sh        <= '0;
      r_mdata     <= '0;
      r_mvalid    <= 1'b0;
      r_mlast     <= 1'b0;
      r_pkt_start <= 1'b0;
      r_pkt_done  <= 1'b0;
      r_crc_ok    <= 1'b0;
      r_len_err   <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      r_pkt_start <= 1'b0;
      r_pkt_done  <= 1'b0;
      r_len_err   <= 1'b0;
      r_ovf       <= 1'b0;
      if (r_mvalid && m_ready) r_mvalid <= 1'b0;

      if (r_state == S_HUNT) begin
        if (rx_bit_valid) begin
          if (w_match) begin
            // Window is cleared here so every later return to HUNT
            // starts from an empty window.
            r_sr        <= '0;
            r_w         <= {ch_idx[0], ch_idx[1], ch_idx[2], ch_idx[3],
                            ch_idx[4], ch_idx[5], 1'b1};
            r_c         <= CRC_INIT;
            r_bitcnt    <= '0;
            r_bytecnt   <= '0;
            r_len       <= '0;
            r_sh        <= '0;
            r_crc_ok    <= 1'b0;
            r_pkt_start <= 1'b1;
          end else begin
            r_sr <= w_sr_next[31:1];
          end
        end
      end else if (rx_bit_valid) begin
        r_w  <= w_w_next;
        r_c  <= w_c_next;
        r_sh <= w_byte[7:1];
        if (w_byte_done) begin
          r_bitcnt <= '0;
          if (w_ovf) begin
            // Pending byte is kept; the new one is dropped
            r_ovf <= 1'b1;
          end else begin
            r_mdata   <= w_byte;
            r_mvalid  <= 1'b1;
            r_mlast   <= w_last_byte;
            r_bytecnt <= r_bytecnt + 8'd1;
            if (w_is_len) begin
              r_len     <= w_byte;
              r_len_err <= w_len_bad;
            end
          end
        end else begin
          r_bitcnt <= r_bitcnt + 5'd1;
        end
        if (w_crc_end) begin
          r_pkt_done <= 1'b1;
          r_crc_ok   <= (w_c_next == 24'd0);
        end
      end
    end
  end

  assign m_data    = r_mdata;
  assign m_valid   = r_mvalid;
  assign m_last    = r_mlast;
  assign pkt_start = r_pkt_start;
  assign pkt_done  = r_pkt_done;
  assign crc_ok    = r_crc_ok;
  assign len_err   = r_len_err;
  assign overflow  = r_ovf;
  assign busy      = w_busy;

endmodule

// File: tb/tb_ble_deframer.sv
// Directed bench for ble_deframer: builds whitened BLE packets with an
// independent CRC-24 model, scoreboards emitted bytes, tracks pulses.
module tb_ble_deframer;

  localparam logic [31:0] AA       = 32'h8E89BED6;
  localparam logic [23:0] CRC_INIT = 24'h555555;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] ch_idx = '0;
  logic       rx_bit = 1'b0;
  logic       rx_bit_valid = 1'b0;
  logic       m_ready = 1'b1;
  logic [7:0] m_data;
  logic       m_valid, m_last, pkt_start, pkt_done, crc_ok, len_err, overflow, busy;

  always #5 clk = ~clk;

  ble_deframer dut (
    .clk(clk), .rst(rst), .ch_idx(ch_idx), .rx_bit(rx_bit), .rx_bit_valid(rx_bit_valid),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .pkt_start(pkt_start), .pkt_done(pkt_done), .crc_ok(crc_ok), .len_err(len_err),
    .overflow(overflow), .busy(busy)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [8:0] sbq[$];
  bit         txq[$];
  logic [7:0] pdu[0:7];
  int         pdu_n;
  int         n_start, n_done, n_len, n_ovf, n_busy, start_cyc, done_cyc;
  logic       done_crc;
  int         aa_cyc, last_cyc;
  logic [8:0] exp_b;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] wstep(input logic [6:0] w);
    return {w[5], w[4], w[3] ^ w[6], w[2], w[1], w[0], w[6]};
  endfunction

  // Transmit side: AA (LSB first), whitened PDU, whitened CRC MSB first
  task automatic build(input logic [5:0] ch, input logic [31:0] aa_mask);
    logic [6:0]  w;
    logic [23:0] c;
    logic        d, fb;
    txq.delete();
    for (int i = 0; i < 32; i++) txq.push_back(AA[i] ^ aa_mask[i]);
    w = {ch[0], ch[1], ch[2], ch[3], ch[4], ch[5], 1'b1};
    c = CRC_INIT;
    for (int k = 0; k < pdu_n; k++) begin
      for (int b = 0; b < 8; b++) begin
        d  = pdu[k][b];
        fb = d ^ c[23];
        c  = {c[22:0], 1'b0} ^ (fb ? 24'h00065B : 24'h000000);
        txq.push_back(d ^ w[6]);
        w  = wstep(w);
      end
    end
    for (int i = 23; i >= 0; i--) begin
      d = c[i];
      txq.push_back(d ^ w[6]);
      w = wstep(w);
    end
  endtask

  task automatic push_exp();
    for (int k = 0; k < pdu_n; k++) sbq.push_back({(k == pdu_n - 1), pdu[k]});
  endtask

  // Bits go out with an idle gap after every fifth one
  task automatic send_range(input int from, input int to);
    for (int i = from; i <= to; i++) begin
      @(negedge clk);
      rx_bit = txq[i];
      rx_bit_valid = 1'b1;
      if (i == 31) aa_cyc = cyc;
      last_cyc = cyc;
      if (i % 5 == 4) begin
        @(negedge clk);
        rx_bit_valid = 1'b0;
        rx_bit = ~rx_bit;
      end
    end
    @(negedge clk);
    rx_bit_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    rx_bit_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic clr();
    n_start = 0; n_done = 0; n_len = 0; n_ovf = 0; n_busy = 0;
    start_cyc = -1; done_cyc = -1; done_crc = 1'bx;
  endtask

  task automatic std_pdu();
    pdu[0] = 8'h02; pdu[1] = 8'h03; pdu[2] = 8'h11; pdu[3] = 8'h22; pdu[4] = 8'h33;
    pdu_n = 5;
  endtask

  // Output monitor and scoreboard
  always @(negedge clk) begin
    if (m_valid && m_ready) begin
      chk("sb_byte_expected", 32'(sbq.size() > 0), 1);
      if (sbq.size() > 0) begin
        exp_b = sbq.pop_front();
        chk("byte_last_data", 32'({m_last, m_data}), 32'(exp_b));
      end
    end
    if (pkt_start) begin n_start++; start_cyc = cyc; end
    if (pkt_done)  begin n_done++; done_cyc = cyc; done_crc = crc_ok; end
    if (len_err)   begin n_len++; chk("busy_at_len_err", 32'(busy), 0); end
    if (overflow)  n_ovf++;
    if (busy)      n_busy++;
  end

  initial begin
    clr();
    repeat (3) @(negedge clk);
    chk("reset_outputs", 32'({m_data, m_valid, m_last, pkt_start, pkt_done,
                              crc_ok, len_err, overflow, busy}), 0);
    rst = 1'b0;
    idle(2);

    // Clean packet, channel 37
    clr(); std_pdu(); ch_idx = 6'd37;
    build(6'd37, 32'h0); push_exp();
    send_range(0, txq.size() - 1); idle(6);
    chk("t1_start_cnt", n_start, 1);
    chk("t1_start_lat", start_cyc, aa_cyc + 1);
    chk("t1_done_cnt", n_done, 1);
    chk("t1_done_lat", done_cyc, last_cyc + 1);
    chk("t1_crc_ok", 32'(done_crc), 1);
    chk("t1_crc_held", 32'(crc_ok), 1);
    chk("t1_sb_empty", sbq.size(), 0);
    chk("t1_busy_idle", 32'(busy), 0);

    // First payload bit flipped on air
    clr(); std_pdu();
    build(6'd37, 32'h0); txq[48] = ~txq[48];
    pdu[2] = 8'h10; push_exp();
    send_range(0, txq.size() - 1); idle(6);
    chk("t2_done_cnt", n_done, 1);
    chk("t2_crc_bad", 32'(done_crc), 0);
    chk("t2_crc_held", 32'(crc_ok), 0);
    chk("t2_sb_empty", sbq.size(), 0);

    // AA with one bit error, random payload
    clr(); ch_idx = 6'd12;
    pdu[0] = 8'h02; pdu[1] = 8'h04; pdu_n = 6;
    for (int k = 2; k < 6; k++) pdu[k] = 8'($urandom_range(0, 255));
    build(6'd12, 32'h0000_0080); push_exp();
    send_range(0, txq.size() - 1); idle(6);
    chk("t3_start_cnt", n_start, 1);
    chk("t3_done_cnt", n_done, 1);
    chk("t3_crc_ok", 32'(done_crc), 1);
    chk("t3_sb_empty", sbq.size(), 0);

    // AA with two bit errors must not lock
    clr(); std_pdu(); ch_idx = 6'd37;
    build(6'd37, 32'h0010_0008);
    send_range(0, txq.size() - 1); idle(6);
    chk("t4_no_start", n_start, 0);
    chk("t4_never_busy", n_busy, 0);
    chk("t4_no_done", n_done, 0);
    chk("t4_sb_empty", sbq.size(), 0);

    // Length 64 exceeds limit
    clr(); ch_idx = 6'd20;
    pdu[0] = 8'h02; pdu[1] = 8'h40; pdu_n = 2;
    build(6'd20, 32'h0);
    sbq.push_back(9'h002); sbq.push_back(9'h140);
    send_range(0, 47); idle(6);
    chk("t5_start_cnt", n_start, 1);
    chk("t5_len_err_cnt", n_len, 1);
    chk("t5_no_done", n_done, 0);
    chk("t5_busy", 32'(busy), 0);
    chk("t5_sb_empty", sbq.size(), 0);

    // Consumer stalled: second byte overflows
    clr(); std_pdu(); ch_idx = 6'd37;
    @(posedge clk); #1 m_ready = 1'b0;
    build(6'd37, 32'h0);
    sbq.push_back(9'h002);
    send_range(0, txq.size() - 1); idle(6);
    chk("t6_ovf_cnt", n_ovf, 1);
    chk("t6_no_done", n_done, 0);
    chk("t6_valid_held", 32'(m_valid), 1);
    chk("t6_data_held", 32'({m_last, m_data}), 32'h002);
    chk("t6_busy", 32'(busy), 0);
    idle(3);
    chk("t6_data_stable", 32'({m_valid, m_data}), 32'h102);
    @(posedge clk); #1 m_ready = 1'b1;
    idle(4);
    chk("t6_drained", 32'(m_valid), 0);
    chk("t6_sb_empty", sbq.size(), 0);

    // Reset mid-payload, then a clean packet
    clr(); std_pdu(); ch_idx = 6'd5;
    build(6'd5, 32'h0);
    sbq.push_back(9'h002); sbq.push_back(9'h003); sbq.push_back(9'h011);
    send_range(0, 58);
    @(negedge clk); rx_bit_valid = 1'b0; rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("t7_reset_outputs", 32'({m_data, m_valid, m_last, pkt_start, pkt_done,
                                 crc_ok, len_err, overflow, busy}), 0);
    chk("t7_sb_partial", sbq.size(), 0);
    clr(); push_exp();
    send_range(0, txq.size() - 1); idle(6);
    chk("t7_done_cnt", n_done, 1);
    chk("t7_crc_ok", 32'(done_crc), 1);
    chk("t7_sb_empty", sbq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
